// File: rtl/hvsync_generator.sv
// Free-running VGA-style raster timing: column/line counters, registered sync pulses, visible-area flag.
// Optional build macro HVSYNC_POSITIVE_SYNC_EN makes hsync/vsync active-high; default is active-low.
module hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic [9:0] H_MAX_C        = 10'(H_MAX);
    localparam logic [9:0] V_MAX_C        = 10'(V_MAX);
    localparam logic [9:0] H_DISPLAY_C    = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISPLAY_C    = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_START_C = 10'(H_SYNC_START);
    localparam logic [9:0] H_SYNC_END_C   = 10'(H_SYNC_END);
    localparam logic [9:0] V_SYNC_START_C = 10'(V_SYNC_START);
    localparam logic [9:0] V_SYNC_END_C   = 10'(V_SYNC_END);

`ifdef HVSYNC_POSITIVE_SYNC_EN
    localparam logic SYNC_ACTIVE = 1'b1;
`else
    localparam logic SYNC_ACTIVE = 1'b0;
`endif
    localparam logic SYNC_IDLE = !SYNC_ACTIVE;

    logic [9:0] hpos_reg, hpos_next;
    logic [9:0] vpos_reg, vpos_next;
    logic       hsync_reg, hsync_next;
    logic       vsync_reg, vsync_next;
    logic       line_end;

    always_comb begin
        line_end   = (hpos_reg == H_MAX_C);
        hpos_next  = hpos_reg + 10'd1;
        vpos_next  = vpos_reg;
        hsync_next = SYNC_IDLE;
        vsync_next = SYNC_IDLE;

        if (line_end) begin
            hpos_next = 10'd0;
            vpos_next = (vpos_reg == V_MAX_C) ? 10'd0 : vpos_reg + 10'd1;
        end

        // Sync levels are decoded from the current position, so the outputs trail the counters by one clock.
        if ((hpos_reg >= H_SYNC_START_C) && (hpos_reg <= H_SYNC_END_C))
            hsync_next = SYNC_ACTIVE;
        if ((vpos_reg >= V_SYNC_START_C) && (vpos_reg <= V_SYNC_END_C))
            vsync_next = SYNC_ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_reg  <= 10'd0;
            vpos_reg  <= 10'd0;
            hsync_reg <= SYNC_IDLE;
            vsync_reg <= SYNC_IDLE;
        end else begin
            hpos_reg  <= hpos_next;
            vpos_reg  <= vpos_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
        end
    end

    assign hpos       = hpos_reg;
    assign vpos       = vpos_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign display_on = (hpos_reg < H_DISPLAY_C) && (vpos_reg < V_DISPLAY_C);

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench: a default-timing instance for line behaviour and a miniature instance for frame behaviour.
module tb_hvsync_generator;

`ifdef HVSYNC_POSITIVE_SYNC_EN
    localparam logic ACT = 1'b1;
`else
    localparam logic ACT = 1'b0;
`endif
    localparam logic IDLE = !ACT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;
    logic       s_hsync, s_vsync, s_display_on;
    logic [9:0] s_hpos, s_vpos;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hvsync_generator dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .hpos(hpos), .vpos(vpos)
    );

    // Miniature raster: 16 clocks/line (sync 10..12), 13 lines/frame (sync lines 8..9), 208 clocks/frame.
    hvsync_generator #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
    ) dut_s (
        .clk(clk), .reset(reset), .hsync(s_hsync), .vsync(s_vsync),
        .display_on(s_display_on), .hpos(s_hpos), .vpos(s_vpos)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hs_first = -1, hs_end = -1, hs_len = 0, vs_def_len = 0;
        int vs_len = 0, vs_fv = -1, vs_fh = -1, vs_ev = -1, vs_eh = -1;
        int f1 = -1, f2 = -1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hpos", hpos, 0);
        check("rst_vpos", vpos, 0);
        check("rst_hsync", hsync, IDLE);
        check("rst_vsync", vsync, IDLE);
        check("rst_display_on", display_on, 1);
        check("rst_s_vsync", s_vsync, IDLE);
        $display("reset: hpos=%0d vpos=%0d hsync=%0b vsync=%0b", hpos, vpos, hsync, vsync);

        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 800; k++) begin
            @(posedge clk);
            #1;
            check("hpos_seq", hpos, k % 800);
            if (hsync == ACT) begin
                hs_len++;
                if (hs_first < 0) hs_first = hpos;
            end else if (hs_first >= 0 && hs_end < 0) begin
                hs_end = hpos;
            end
            if (vsync == ACT) vs_def_len++;
            if (k == 639) check("disp_639_0", display_on, 1);
            if (k == 640) check("disp_640_0", display_on, 0);
            if (k == 799) check("vpos_before_wrap", vpos, 0);
            if (k == 800) check("vpos_after_wrap", vpos, 1);

            if (k <= 208) begin
                if (s_vsync == ACT) begin
                    vs_len++;
                    if (vs_fv < 0) begin vs_fv = s_vpos; vs_fh = s_hpos; end
                end else if (vs_fv >= 0 && vs_ev < 0) begin
                    vs_ev = s_vpos; vs_eh = s_hpos;
                end
            end
            if (s_hpos == 0 && s_vpos == 0) begin
                if (f1 < 0) f1 = k;
                else if (f2 < 0) f2 = k;
            end
            if (k == 7)   check("s_disp_7_0", s_display_on, 1);
            if (k == 8)   check("s_disp_8_0", s_display_on, 0);
            if (k == 80)  check("s_disp_0_5", s_display_on, 1);
            if (k == 96)  check("s_disp_0_6", s_display_on, 0);
            if (k == 207) check("s_disp_15_12", s_display_on, 0);
        end
        check("hsync_len", hs_len, 96);
        check("hsync_first_hpos", hs_first, 657);
        check("hsync_end_hpos", hs_end, 753);
        check("vsync_idle_line0", vs_def_len, 0);
        $display("line: hsync active %0d clocks from hpos %0d to before hpos %0d", hs_len, hs_first, hs_end);
        check("s_vsync_len", vs_len, 32);
        check("s_vsync_first_vpos", vs_fv, 8);
        check("s_vsync_first_hpos", vs_fh, 1);
        check("s_vsync_end_vpos", vs_ev, 10);
        check("s_vsync_end_hpos", vs_eh, 1);
        check("s_frame_first", f1, 208);
        check("s_frame_period", f2 - f1, 208);
        $display("frame: vsync active %0d clocks, frame period %0d", vs_len, f2 - f1);

        // Asynchronous reset while hsync is active
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(700);
        check("pre_rst_hpos", hpos, 700);
        check("pre_rst_hsync", hsync, ACT);
        #2;
        reset = 1'b1;
        #1;
        check("async_hpos", hpos, 0);
        check("async_vpos", vpos, 0);
        check("async_hsync", hsync, IDLE);
        check("async_display_on", display_on, 1);
        $display("async reset at hpos 700: hpos=%0d hsync=%0b", hpos, hsync);
        @(negedge clk);
        reset = 1'b0;
        step(1);
        check("release_hpos", hpos, 1);
        check("release_s_hpos", s_hpos, 1);

        // Asynchronous reset while vsync is active on the miniature raster
        step(132);
        check("pre_rst_s_vpos", s_vpos, 8);
        check("pre_rst_s_vsync", s_vsync, ACT);
        #2;
        reset = 1'b1;
        #1;
        check("async_s_vpos", s_vpos, 0);
        check("async_s_hpos", s_hpos, 0);
        check("async_s_vsync", s_vsync, IDLE);
        $display("async reset at s(5,8): s_hpos=%0d s_vpos=%0d s_vsync=%0b", s_hpos, s_vpos, s_vsync);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hvsync_generator.md
HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 Parameters: H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameters: H_FRONT, 16, horizontal front porch clocks.
REQ-003 Parameters: H_SYNC, 96, horizontal sync width clocks.
REQ-004 Parameters: H_BACK, 48, horizontal back porch clocks.
REQ-005 Parameters: V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameters: V_BOTTOM, 10, vertical front porch lines.
REQ-007 Parameters: V_SYNC, 2, vertical sync width lines.
REQ-008 Parameters: V_TOP, 33, vertical back porch lines.
REQ-009 Port: clk  input  1  pixel clock; all state on rising edge.
REQ-010 Port: reset  input  1  asynchronous, active-high reset.
REQ-011 Port: hsync  output  1  horizontal sync, registered, active-low by default.
REQ-012 Port: vsync  output  1  vertical sync, registered, active-low by default.
REQ-013 Port: display_on  output  1  high while the current position is in the visible area.
REQ-014 Port: hpos  output  10  current column counter.
REQ-015 Port: vpos  output  10  current line counter.

Function
REQ-016 Derived constants: H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 (799); V_MAX = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP-1 (524).
REQ-017 Derived constants: H_SYNC_START = H_DISPLAY+H_FRONT (656); H_SYNC_END = H_SYNC_START+H_SYNC-1 (751); V_SYNC_START = V_DISPLAY+V_BOTTOM (490); V_SYNC_END = V_SYNC_START+V_SYNC-1 (491).
REQ-018 hpos increments by 1 every clock; at H_MAX it wraps to 0 on the next clock.
REQ-019 vpos increments by 1 only on the clock where hpos wraps (hpos==H_MAX); when vpos==V_MAX at that clock it wraps to 0.
REQ-020 Frame period = (H_MAX+1)*(V_MAX+1) clocks (420000 by default).
REQ-021 hsync register is loaded each clock with its active level iff the current hpos is within [H_SYNC_START, H_SYNC_END]; the output therefore lags hpos by one clock (first active at hpos==657, last active at hpos==752).
REQ-022 vsync register is loaded each clock with its active level iff the current vpos is within [V_SYNC_START, V_SYNC_END]; it lags vpos by one clock.
REQ-023 display_on is combinational: (hpos < H_DISPLAY) and (vpos < V_DISPLAY); no lag.
REQ-024 Counters hold 10 bits; parameter sets whose H_MAX or V_MAX exceed 1023 are unsupported.
REQ-025 No other inputs; the generator free-runs continuously after reset release.

Reset
REQ-026 While reset is high: hpos=0, vpos=0, hsync and vsync at inactive level (1 by default), regardless of clk.
REQ-027 Reset asserted mid-line or mid-frame takes effect immediately; after release the first rising edge advances hpos to 1.
REQ-028 display_on is 1 during reset (position 0,0).

Configuration
REQ-029 Macro HVSYNC_POSITIVE_SYNC_EN: when defined, hsync and vsync are active-high (inactive and reset level 0); when undefined, both are active-low (inactive and reset level 1). Counter timing is identical in both builds.

Verification
REQ-030 Assert reset, release, count 800 clocks -> hpos sequence 1..799 then 0, vpos 0 -> 1 on the wrap.
REQ-031 Run from reset, sample hsync -> low for exactly 96 consecutive clocks per line, first low while hpos==657, high again while hpos==753.
REQ-032 Run one full frame -> vsync low for exactly 1600 clocks (2 lines), starting one clock after vpos becomes 490; frame repeats every 420000 clocks.
REQ-033 Check display_on at (639,0)=1, (640,0)=0, (0,479)=1, (0,480)=0, (799,524)=0.
REQ-034 Assert reset at hpos=300,vpos=200 without a clock edge -> hpos=0, vpos=0, hsync=vsync=1 immediately.
REQ-035 Build with HVSYNC_POSITIVE_SYNC_EN -> hsync/vsync 0 during reset, high for the same 96-clock/2-line windows.
